mem_lsu: RTL
============

# mem_lsu

Load/store unit for the MEM stage of the MIPS core, directly upstream of the data RAM. Accepts one memory request at a time from the pipeline over a valid/ready handshake. Checks alignment, then drives the RAM's chip-enable, write-enable, byte-select and write-data lanes for a single access cycle. Extracts and sign- or zero-extends load data, and returns a registered response with exception status.

## Interface
- `ADDR_W`, default 32: width of request and RAM address.

- `clk` input 1: clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept a request.
- `req_op` input 4: operation code.
  - 0000 LB, 0001 LBU, 0010 LH, 0011 LHU, 0100 LW.
  - 1000 SB, 1001 SH, 1010 SW.
  - All other codes are reserved.
- `req_addr` input ADDR_W: byte address.
- `req_wdata` input 32: store data, right-aligned.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: pipeline consumes the response.
- `rsp_rdata` output 32: extended load result; 0 for stores, faults and reserved ops.
- `rsp_excp` output 2: 00 none, 01 AdEL, 10 AdES, 11 reserved op.
- `rsp_badaddr` output ADDR_W: faulting address when `rsp_excp` is 01 or 10, else 0.
- `ram_ce` output 1: RAM chip enable.
- `ram_we` output 1: RAM write enable.
- `ram_addr` output ADDR_W: word address to RAM, bits [1:0] forced to 00.
- `ram_sel` output 4: byte-lane enables; bit n selects data[8n+7:8n].
- `ram_wdata` output 32: lane-positioned store data.
- `ram_rdata` input 32: combinational RAM read data, valid while `ram_ce`=1 and `ram_we`=0.

## Operation
FSM states:
- IDLE
  - `req_ready`=1.
  - On `req_valid`, latch op, addr and wdata.
  - Misaligned or reserved op: go to RESP with the exception code set. No RAM access.
  - Otherwise: go to ACCESS.
- ACCESS
  - Drives the RAM for exactly one cycle, then goes to RESP.
  - Loads: `ram_rdata` is sampled at the closing edge into the result register.
- RESP
  - `rsp_valid`=1. Response outputs are held stable.
  - Goes to IDLE on `rsp_ready`; otherwise stays in RESP.

Alignment rules:
- Halfword ops require addr[0]=0.
- Word ops require addr[1:0]=00.
- A load fault gives AdEL; a store fault gives AdES.
- On a fault, `rsp_badaddr` is the request address.

Byte lanes (little-endian, lane k = addr[1:0]):
- SB: `ram_sel` = 0001<<k; `ram_wdata` = byte replicated 4×.
- SH: `ram_sel` = 0011 if addr[1]=0, else 1100; `ram_wdata` = halfword replicated 2×.
- SW: `ram_sel` = 1111; `ram_wdata` = wdata.
- Loads: `ram_sel` = 1111, `ram_we`=0.
  - LB/LBU select byte k of the read word; LH/LHU select halfword addr[1].
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-fill.

Outside ACCESS: `ram_ce`, `ram_we`, `ram_sel`, `ram_addr` and `ram_wdata` are all 0.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready`=1.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_excp`=00, `rsp_badaddr`=0.
  - All `ram_*` outputs 0.
- Reset applies asynchronously.
  - Asserting `rst_n` low in ACCESS forces `ram_ce`/`ram_we` low immediately. A store in progress is dropped if reset is asserted before the write edge.
  - A pending response is discarded.
- Latency, with a request accepted at edge N:
  - ACCESS occupies cycle N..N+1.
  - `rsp_valid` rises after edge N+1.
  - Faulting or reserved requests: `rsp_valid` rises after edge N, with no ACCESS cycle.
- `req_ready` is 0 in ACCESS and RESP. No new request is accepted in the cycle a response is consumed.
  - Throughput: one request per 3 cycles when `rsp_ready` is held at 1.
- Response outputs are registered and do not change while `rsp_valid`=1 and `rsp_ready`=0.
- `rsp_rdata` of a store equals 0.

## Test plan
- Reset, then SW addr 0x0000_0010, data 0xDEADBEEF → one ACCESS cycle with `ram_ce`=1, `ram_we`=1, `ram_sel`=1111, `ram_addr`=0x10. Response follows with excp 00.
- SB addr 0x13, data 0x000000A5 → `ram_sel`=1000, `ram_wdata`=0xA5A5A5A5. Then LB 0x13 with `ram_rdata`=0xA5000000 → `rsp_rdata`=0xFFFFFFA5; LBU 0x13 → 0x000000A5.
- LH 0x22 with `ram_rdata`=0x80017FFF → `rsp_rdata`=0xFFFF8001; LHU 0x20 → 0x00007FFF.
- LW 0x6 → `rsp_excp`=01, `rsp_badaddr`=0x6, `ram_ce` never asserted, `rsp_valid` one cycle after accept. SH 0x5 → `rsp_excp`=10. Op 0111 → `rsp_excp`=11.
- Hold `rsp_ready`=0 for 4 cycles after an LW response → `rsp_valid` and `rsp_rdata` stable and `req_ready`=0 throughout. Release → IDLE on the next edge.
- Pull `rst_n` low mid-ACCESS of SW → `ram_we` drops without waiting for a clock edge, and the RAM word is unchanged. After release, `req_ready`=1 and `rsp_valid`=0.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit sitting in front of the data RAM.
// Accepts one request at a time, checks alignment and op legality, drives
// the RAM for a single access cycle and returns a registered response with
// the extended load data and exception status.
module mem_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_excp,
    output logic [ADDR_W-1:0] rsp_badaddr,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_sel,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LBU = 4'b0001;
    localparam logic [3:0] OP_LH  = 4'b0010;
    localparam logic [3:0] OP_LHU = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [3:0]        op_r;
    logic [1:0]        addr_lo_r;
    logic [1:0]        req_excp_s;
    logic [3:0]        req_sel_s;
    logic [31:0]       req_wlanes_s;
    logic [31:0]       load_data_s;
    logic [7:0]        load_byte_s;
    logic [15:0]       load_half_s;
    logic              ram_ce_r, ram_we_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic [3:0]        ram_sel_r;
    logic [31:0]       ram_wdata_r;
    logic [31:0]       rsp_rdata_r;
    logic [1:0]        rsp_excp_r;
    logic [ADDR_W-1:0] rsp_badaddr_r;

    // Classify the incoming request: legal, misaligned load/store, or reserved.
    always_comb begin
        req_excp_s = 2'b00;
        case (req_op)
            OP_LB, OP_LBU, OP_SB: req_excp_s = 2'b00;
            OP_LH, OP_LHU:        req_excp_s = req_addr[0] ? 2'b01 : 2'b00;
            OP_LW:                req_excp_s = (req_addr[1:0] != 2'b00) ? 2'b01 : 2'b00;
            OP_SH:                req_excp_s = req_addr[0] ? 2'b10 : 2'b00;
            OP_SW:                req_excp_s = (req_addr[1:0] != 2'b00) ? 2'b10 : 2'b00;
            default:              req_excp_s = 2'b11;
        endcase
    end

    // Byte-lane enables and lane-positioned write data for the incoming request.
    always_comb begin
        req_sel_s    = 4'b1111;
        req_wlanes_s = 32'h0000_0000;
        case (req_op)
            OP_SB: begin
                req_sel_s    = 4'b0001 << req_addr[1:0];
                req_wlanes_s = {4{req_wdata[7:0]}};
            end
            OP_SH: begin
                req_sel_s    = req_addr[1] ? 4'b1100 : 4'b0011;
                req_wlanes_s = {2{req_wdata[15:0]}};
            end
            OP_SW: begin
                req_sel_s    = 4'b1111;
                req_wlanes_s = req_wdata;
            end
            default: begin
                req_sel_s    = 4'b1111;
                req_wlanes_s = 32'h0000_0000;
            end
        endcase
    end

    // Pick the addressed byte/halfword out of the read word and extend it.
    always_comb begin
        load_data_s = 32'h0000_0000;
        case (addr_lo_r)
            2'b00:   load_byte_s = ram_rdata[7:0];
            2'b01:   load_byte_s = ram_rdata[15:8];
            2'b10:   load_byte_s = ram_rdata[23:16];
            2'b11:   load_byte_s = ram_rdata[31:24];
            default: load_byte_s = 8'h00;
        endcase
        if (addr_lo_r[1]) begin
            load_half_s = ram_rdata[31:16];
        end else begin
            load_half_s = ram_rdata[15:0];
        end
        case (op_r)
            OP_LB:   load_data_s = {{24{load_byte_s[7]}}, load_byte_s};
            OP_LBU:  load_data_s = {24'h00_0000, load_byte_s};
            OP_LH:   load_data_s = {{16{load_half_s[15]}}, load_half_s};
            OP_LHU:  load_data_s = {16'h0000, load_half_s};
            OP_LW:   load_data_s = ram_rdata;
            default: load_data_s = 32'h0000_0000;
        endcase
    end

    // Next-state logic: faults skip the RAM cycle and go straight to RESP.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_s = (req_excp_s != 2'b00) ? RESP : ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: state_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request latch, RAM drive registers and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r          <= 4'b0000;
            addr_lo_r     <= 2'b00;
            ram_ce_r      <= 1'b0;
            ram_we_r      <= 1'b0;
            ram_addr_r    <= {ADDR_W{1'b0}};
            ram_sel_r     <= 4'b0000;
            ram_wdata_r   <= 32'h0000_0000;
            rsp_rdata_r   <= 32'h0000_0000;
            rsp_excp_r    <= 2'b00;
            rsp_badaddr_r <= {ADDR_W{1'b0}};
        end else if (state_r == IDLE && req_valid) begin
            op_r        <= req_op;
            addr_lo_r   <= req_addr[1:0];
            rsp_rdata_r <= 32'h0000_0000;
            rsp_excp_r  <= req_excp_s;
            if (req_excp_s == 2'b01 || req_excp_s == 2'b10) begin
                rsp_badaddr_r <= req_addr;
            end else begin
                rsp_badaddr_r <= {ADDR_W{1'b0}};
            end
            if (req_excp_s == 2'b00) begin
                ram_ce_r    <= 1'b1;
                ram_we_r    <= req_op[3];
                ram_addr_r  <= {req_addr[ADDR_W-1:2], 2'b00};
                ram_sel_r   <= req_sel_s;
                ram_wdata_r <= req_wlanes_s;
            end else begin
                ram_ce_r    <= 1'b0;
                ram_we_r    <= 1'b0;
                ram_addr_r  <= {ADDR_W{1'b0}};
                ram_sel_r   <= 4'b0000;
                ram_wdata_r <= 32'h0000_0000;
            end
        end else if (state_r == ACCESS) begin
            ram_ce_r    <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= {ADDR_W{1'b0}};
            ram_sel_r   <= 4'b0000;
            ram_wdata_r <= 32'h0000_0000;
            if (!op_r[3]) begin
                rsp_rdata_r <= load_data_s;
            end else begin
                rsp_rdata_r <= 32'h0000_0000;
            end
        end else begin
            ram_ce_r <= 1'b0;
            ram_we_r <= 1'b0;
        end
    end

    assign req_ready   = (state_r == IDLE);
    assign rsp_valid   = (state_r == RESP);
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_excp    = rsp_excp_r;
    assign rsp_badaddr = rsp_badaddr_r;
    assign ram_ce      = ram_ce_r;
    assign ram_we      = ram_we_r;
    assign ram_addr    = ram_addr_r;
    assign ram_sel     = ram_sel_r;
    assign ram_wdata   = ram_wdata_r;

endmodule
